// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH and
//   borrow = (a < b), computed LSB-first with one subtractor cell and a
//   borrow flip-flop, one bit per clock. A result is presented exactly
//   WIDTH cycles after the operands are accepted.
//
// Ports
//   clk       : clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands a/b present
//   in_ready  : block can accept operands (high only in IDLE)
//   a, b      : minuend / subtrahend (WIDTH bits)
//   out_valid : diff/borrow valid (high only in DONE)
//   out_ready : consumer accepts result
//   diff      : (a - b) mod 2^WIDTH
//   borrow    : 1 iff a < b (unsigned)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // One extra bit so WIDTH=32 never wraps the counter.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg, diff_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;

  logic             x, y, bi, d, bo;
  logic             last_bit;
  logic [WIDTH-1:0] d_vec;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    x        = sa_reg[0];
    y        = sb_reg[0];
    bi       = borrow_reg;
    d        = x ^ y ^ bi;
    bo       = (~x & y) | (~(x ^ y) & bi);
    last_bit = (cnt_reg == CW'(WIDTH - 1));
    // Result bit enters at the MSB end; after WIDTH right-shifts the
    // first-computed bit lands at diff[0]. Built this way so WIDTH=1 works.
    d_vec            = '0;
    d_vec[WIDTH-1]   = d;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sa_reg     <= a;
            sb_reg     <= b;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          sa_reg     <= sa_reg >> 1;
          sb_reg     <= sb_reg >> 1;
          diff_reg   <= (diff_reg >> 1) | d_vec;
          borrow_reg <= bo;
          cnt_reg    <= cnt_reg + CW'(1);
        end
        default: ;  // DONE: hold result under backpressure
      endcase
    end
  end

  // All outputs come from registers or the state decode only.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign borrow    = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         in_ready, out_valid, borrow;
  logic [W-1:0] diff;

  // WIDTH=1 instance
  logic         iv1 = 1'b0, or1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         ir1, ov1, borrow1;
  logic [0:0]   diff1;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a_i), .b(b_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1),
    .diff(diff1), .borrow(borrow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // One full transaction: accept, wait for result, optional stall, drain.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int stall, input bit noise);
    int         cyc;
    logic [W:0] e;
    wait_ready();
    a_i = av; b_i = bv; in_valid = 1'b1;
    exp_q.push_back({1'b0, av} - {1'b0, bv});
    tick();  // accept edge
    if (noise) begin
      a_i = 8'd1; b_i = 8'd1; in_valid = 1'b1;
    end else begin
      a_i = 'x; b_i = 'x; in_valid = 1'b0;
    end
    check("accept_in_ready", 32'(in_ready), 32'd0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(W));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("diff", 32'(diff), 32'(e[W-1:0]));
    check("borrow", 32'(borrow), 32'(e[W]));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_diff", 32'(diff), 32'(e[W-1:0]));
      check("stall_borrow", 32'(borrow), 32'(e[W]));
    end
    out_ready = 1'b1;
    in_valid = 1'b0; a_i = '0; b_i = '0;
    tick();  // drain edge
    out_ready = 1'b0;
    $display("op a=%0d b=%0d diff=%0d borrow=%0d stall=%0d", av, bv, diff, borrow, stall);
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [0:0]   x1, y1;
    int           cyc;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_op(8'd200, 8'd55, 0, 1'b0);
    run_op(8'd5, 8'd9, 0, 1'b0);
    run_op(8'd0, 8'd255, 0, 1'b0);
    run_op(8'hAA, 8'hAA, 0, 1'b0);
    run_op(8'd255, 8'd0, 0, 1'b0);
    // Backpressure plus ignored input during RUN and DONE
    run_op(8'd200, 8'd55, 6, 1'b1);
    run_op(8'd3, 8'd4, 6, 1'b0);

    // Asynchronous reset mid-operation
    wait_ready();
    a_i = 8'd100; b_i = 8'd30; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    run_op(8'd100, 8'd30, 0, 1'b0);

    // Randomised back-to-back with random stalls
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // WIDTH=1 instance: exhaustive then random
    for (int i = 0; i < 40; i++) begin
      if (i < 4) begin
        x1 = 1'(i >> 1); y1 = 1'(i);
      end else begin
        x1 = 1'($urandom); y1 = 1'($urandom);
      end
      check("w1_in_ready", 32'(ir1), 32'd1);
      a1 = x1; b1 = y1; iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      cyc = 0;
      while (ov1 !== 1'b1 && cyc < 20) begin
        tick();
        cyc++;
      end
      check("w1_latency", 32'(cyc), 32'd1);
      check("w1_diff", 32'(diff1), 32'(x1 ^ y1));
      check("w1_borrow", 32'(borrow1), 32'(~x1 & y1));
      $display("w1 a=%0d b=%0d diff=%0d borrow=%0d", x1, y1, diff1, borrow1);
      or1 = 1'b1;
      tick();
      or1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes diff = a - b (mod 2^WIDTH) and a final borrow, LSB-first, one bit per clock.
- Uses a single half/full-subtractor cell and a borrow flip-flop.
- Inverse-direction companion to the team's adder cells, for area-constrained datapaths where one result every WIDTH cycles is acceptable.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1 to 32).

Ports:
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  diff/borrow valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b) mod 2^WIDTH
- borrow  output  1  1 iff a < b (unsigned)

Interface rule (already decided): one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE; shift registers, bit counter, borrow FF and diff all cleared to 0.
  - in_ready=1, out_valid=0, diff=0, borrow=0.
  - Any operation in progress is discarded; no partial result is ever presented.
- States: IDLE, RUN, DONE. State encoding is implementation choice. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1: capture a into sa and b into sb; clear borrow FF; clear counter; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0. in_valid and a/b are ignored.
  - Each edge processes bit x=sa[0], y=sb[0], bi=borrow FF:
    - d = x ^ y ^ bi
    - bo = (~x & y) | (~(x ^ y) & bi)
  - d is shifted into the diff register from the MSB end (right shift), so after WIDTH shifts bit 0 sits at diff[0]. sa and sb shift right; borrow FF <= bo; counter increments.
  - The edge that processes bit WIDTH-1 moves to DONE, and the borrow output takes the final bo.
- Latency: operands accepted at edge E0 are processed at edges E1..E_WIDTH. out_valid rises after E_WIDTH, i.e. exactly WIDTH cycles after acceptance.
- DONE:
  - out_valid=1, in_ready=0.
  - diff and borrow held stable for as long as out_ready=0 (unbounded backpressure).
  - On an edge with out_ready=1: go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - diff and borrow keep their last values in IDLE; they are meaningful only while out_valid=1.
- Throughput: one result per WIDTH+2 cycles with no backpressure. There is no accept-while-done bypass.
- The counter must be wide enough for WIDTH=32 ($clog2(WIDTH)+1 bits). There is no wrap within an operation.
- WIDTH=1 degenerates to a single-cycle RUN: diff=a^b, borrow=~a&b.
- in_valid held high continuously: exactly one operand set is captured per IDLE visit.
- X on a/b is permitted whenever in_ready=0 or in_valid=0.

Test Plan:
- a=200, b=55, in_valid pulsed in IDLE, out_ready=1 -> out_valid exactly 8 cycles after accept; diff=145, borrow=0; in_ready=1 two cycles after accept+8.
- a=5, b=9 -> diff=8'hFC (252), borrow=1. Also a=0, b=255 -> diff=1, borrow=1.
- a=b=8'hAA -> diff=0, borrow=0. Also a=255, b=0 -> diff=255, borrow=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 6 cycles after out_valid -> diff/borrow/out_valid stable and in_ready=0 throughout.
  - Present new in_valid with a=1, b=1 during RUN and DONE -> ignored; first result unchanged.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously after 3 RUN cycles (a=100, b=30) -> outputs immediately 0, in_ready=1, state IDLE.
  - After release, run a=100, b=30 -> diff=70, borrow=0 after 8 cycles.
- Randomised back-to-back operations, WIDTH=8 and WIDTH=1 builds, compared against reference model {borrow,diff} = {1'b0,a} - {1'b0,b}, with random out_ready stalls -> zero mismatches over 1000 operations.
